// File: rtl/axi4_dma_write.sv
// AXI4 write-only DMA traffic engine: issues num_burst INCR bursts of counter-pattern data
// under an ap_start/ap_done handshake and reports the elapsed clocks of each run.
module axi4_dma_write (
    input  logic         clk,
    input  logic         reset,
    output logic         io_axi_awvalid,
    input  logic         io_axi_awready,
    output logic [63:0]  io_axi_awaddr,
    output logic         io_axi_awid,
    output logic [7:0]   io_axi_awlen,
    output logic [2:0]   io_axi_awsize,
    output logic [1:0]   io_axi_awburst,
    output logic         io_axi_wvalid,
    input  logic         io_axi_wready,
    output logic [511:0] io_axi_wdata,
    output logic [63:0]  io_axi_wstrb,
    output logic         io_axi_wlast,
    input  logic         io_axi_bvalid,
    output logic         io_axi_bready,
    input  logic         io_axi_bid,
    input  logic [1:0]   io_axi_bresp,
    input  logic [63:0]  io_start_addr,
    input  logic [7:0]   io_len_burst,
    input  logic [31:0]  io_num_burst,
    input  logic [7:0]   io_stride,
    output logic [31:0]  io_cnt_clk,
    input  logic         io_ap_start,
    output logic         io_ap_ready,
    output logic         io_ap_done,
    output logic         io_ap_idle
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [63:0] awaddr_q, awaddr_d;
    logic [7:0]  len_q, len_d;
    logic [31:0] num_q, num_d;
    logic [7:0]  stride_q, stride_d;
    logic [31:0] aw_cnt_q, aw_cnt_d;
    logic [31:0] w_burst_cnt_q, w_burst_cnt_d;
    logic [7:0]  beat_idx_q, beat_idx_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [31:0] b_cnt_q, b_cnt_d;
    logic [31:0] cnt_clk_q, cnt_clk_d;
    logic        aw_hs, w_hs;
    logic        unused_b;

    // B responses carry no information this engine acts on.
    assign unused_b = ^{io_axi_bid, io_axi_bresp};

    assign io_axi_awvalid = (state_q == S_RUN) && (aw_cnt_q < num_q);
    assign io_axi_wvalid  = (state_q == S_RUN) && (w_burst_cnt_q < num_q);
    assign io_axi_wlast   = io_axi_wvalid && (beat_idx_q == len_q);
    assign io_axi_awaddr  = awaddr_q;
    assign io_axi_awlen   = len_q;
    assign io_axi_awid    = 1'b0;
    assign io_axi_awsize  = 3'd6;
    assign io_axi_awburst = 2'b01;
    assign io_axi_wdata   = {16{beat_cnt_q}};
    assign io_axi_wstrb   = '1;
    assign io_axi_bready  = 1'b1;
    assign io_cnt_clk     = cnt_clk_q;
    assign io_ap_done     = (state_q == S_DONE);
    assign io_ap_ready    = (state_q == S_DONE);
    assign io_ap_idle     = (state_q == S_IDLE);
    assign aw_hs          = io_axi_awvalid && io_axi_awready;
    assign w_hs           = io_axi_wvalid && io_axi_wready;

    always_comb begin
        state_d       = state_q;
        awaddr_d      = awaddr_q;
        len_d         = len_q;
        num_d         = num_q;
        stride_d      = stride_q;
        aw_cnt_d      = aw_cnt_q;
        w_burst_cnt_d = w_burst_cnt_q;
        beat_idx_d    = beat_idx_q;
        beat_cnt_d    = beat_cnt_q;
        b_cnt_d       = b_cnt_q;
        cnt_clk_d     = cnt_clk_q;
        case (state_q)
            S_IDLE: begin
                if (io_ap_start) begin
                    state_d       = S_RUN;
                    awaddr_d      = io_start_addr;
                    len_d         = io_len_burst;
                    num_d         = io_num_burst;
                    stride_d      = io_stride;
                    aw_cnt_d      = '0;
                    w_burst_cnt_d = '0;
                    beat_idx_d    = '0;
                    beat_cnt_d    = '0;
                    b_cnt_d       = '0;
                    cnt_clk_d     = '0;
                end
            end
            S_RUN: begin
                cnt_clk_d = cnt_clk_q + 32'd1;
                // Running address equals start + aw_cnt*stride*64 modulo 2^64.
                if (aw_hs) begin
                    aw_cnt_d = aw_cnt_q + 32'd1;
                    awaddr_d = awaddr_q + {50'd0, stride_q, 6'd0};
                end
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    if (io_axi_wlast) begin
                        beat_idx_d    = '0;
                        w_burst_cnt_d = w_burst_cnt_q + 32'd1;
                    end else begin
                        beat_idx_d = beat_idx_q + 8'd1;
                    end
                end
                if (io_axi_bvalid && (b_cnt_q < num_q)) begin
                    b_cnt_d = b_cnt_q + 32'd1;
                end
                if (b_cnt_q == num_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            awaddr_q      <= '0;
            len_q         <= '0;
            num_q         <= '0;
            stride_q      <= '0;
            aw_cnt_q      <= '0;
            w_burst_cnt_q <= '0;
            beat_idx_q    <= '0;
            beat_cnt_q    <= '0;
            b_cnt_q       <= '0;
            cnt_clk_q     <= '0;
        end else begin
            state_q       <= state_d;
            awaddr_q      <= awaddr_d;
            len_q         <= len_d;
            num_q         <= num_d;
            stride_q      <= stride_d;
            aw_cnt_q      <= aw_cnt_d;
            w_burst_cnt_q <= w_burst_cnt_d;
            beat_idx_q    <= beat_idx_d;
            beat_cnt_q    <= beat_cnt_d;
            b_cnt_q       <= b_cnt_d;
            cnt_clk_q     <= cnt_clk_d;
        end
    end
endmodule

// File: tb/tb_axi4_dma_write.sv
// Bench for axi4_dma_write: AXI slave model with stallable ready/B, expected-queue scoreboard
// for AW/W beats, and per-scenario tasks checking handshake, timing and reset behaviour.
module tb_axi4_dma_write;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         io_axi_awvalid, io_axi_awready = 1'b0;
    logic [63:0]  io_axi_awaddr;
    logic         io_axi_awid;
    logic [7:0]   io_axi_awlen;
    logic [2:0]   io_axi_awsize;
    logic [1:0]   io_axi_awburst;
    logic         io_axi_wvalid, io_axi_wready = 1'b0;
    logic [511:0] io_axi_wdata;
    logic [63:0]  io_axi_wstrb;
    logic         io_axi_wlast;
    logic         io_axi_bvalid = 1'b0, io_axi_bready;
    logic         io_axi_bid = 1'b0;
    logic [1:0]   io_axi_bresp = 2'd0;
    logic [63:0]  io_start_addr = '0;
    logic [7:0]   io_len_burst = '0;
    logic [31:0]  io_num_burst = '0;
    logic [7:0]   io_stride = '0;
    logic [31:0]  io_cnt_clk;
    logic         io_ap_start = 1'b0, io_ap_ready, io_ap_done, io_ap_idle;

    axi4_dma_write dut (
        .clk(clk), .reset(reset),
        .io_axi_awvalid(io_axi_awvalid), .io_axi_awready(io_axi_awready),
        .io_axi_awaddr(io_axi_awaddr), .io_axi_awid(io_axi_awid), .io_axi_awlen(io_axi_awlen),
        .io_axi_awsize(io_axi_awsize), .io_axi_awburst(io_axi_awburst),
        .io_axi_wvalid(io_axi_wvalid), .io_axi_wready(io_axi_wready),
        .io_axi_wdata(io_axi_wdata), .io_axi_wstrb(io_axi_wstrb), .io_axi_wlast(io_axi_wlast),
        .io_axi_bvalid(io_axi_bvalid), .io_axi_bready(io_axi_bready),
        .io_axi_bid(io_axi_bid), .io_axi_bresp(io_axi_bresp),
        .io_start_addr(io_start_addr), .io_len_burst(io_len_burst),
        .io_num_burst(io_num_burst), .io_stride(io_stride), .io_cnt_clk(io_cnt_clk),
        .io_ap_start(io_ap_start), .io_ap_ready(io_ap_ready),
        .io_ap_done(io_ap_done), .io_ap_idle(io_ap_idle)
    );

    // Clock / cycle count
    always #5 clk = ~clk;
    int cyc = 0;
    initial forever begin @(posedge clk); cyc++; end

    int n_checks = 0, n_pass = 0;
    logic [71:0]  exp_aw_q[$];
    logic [512:0] exp_w_q[$];
    int  aw_hs_cnt = 0, w_hs_cnt = 0, wl_hs_cnt = 0, b_sent = 0, done_cnt = 0;
    int  start_cyc = 0, exp_cnt_clk = 0, aw_hold = 0;
    bit  running = 0, any_valid = 0, w_toggle = 0, rand_ready = 0, b_hold = 0;

    // Slave ready / B driver: B for a burst only once both its AW and last W were accepted.
    initial forever begin
        int credit;
        @(posedge clk); #1;
        io_axi_bid   = 1'($urandom_range(0, 1));
        io_axi_bresp = 2'($urandom_range(0, 3));
        if (aw_hold > 0) begin io_axi_awready = 1'b0; aw_hold--; end
        else io_axi_awready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (w_toggle) io_axi_wready = ~io_axi_wready;
        else io_axi_wready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        credit = ((aw_hs_cnt < wl_hs_cnt) ? aw_hs_cnt : wl_hs_cnt) - b_sent;
        if (reset && !b_hold && credit > 0) begin io_axi_bvalid = 1'b1; b_sent++; end
        else io_axi_bvalid = 1'b0;
    end

    // Monitor / scoreboard, sampled on the falling edge.
    initial begin
        bit aw_stalled = 0, w_stalled = 0;
        logic [71:0] aw_prev;
        logic [512:0] w_prev, got_w, exp_w;
        logic [71:0] got_aw, exp_aw;
        forever begin
            @(negedge clk);
            if (!reset) begin aw_stalled = 0; w_stalled = 0; continue; end
            if (io_axi_awvalid || io_axi_wvalid) any_valid = 1;
            if (running) begin
                n_checks++;
                if (io_ap_idle !== 1'b0) $display("FAIL busy_idle: ap_idle=%b want 0 at cyc %0d", io_ap_idle, cyc);
                else n_pass++;
            end
            if (io_ap_idle && io_ap_start) begin running = 1; start_cyc = cyc + 1; end
            if (io_ap_done) begin
                n_checks++;
                if (io_ap_ready !== 1'b1) $display("FAIL ap_ready: got %b want 1 with ap_done", io_ap_ready);
                else n_pass++;
                done_cnt++; exp_cnt_clk = cyc - start_cyc; running = 0;
            end
            got_aw = {io_axi_awlen, io_axi_awaddr};
            if (aw_stalled) begin
                n_checks++;
                if (!io_axi_awvalid || got_aw !== aw_prev)
                    $display("FAIL aw_stable: got v=%b %h want v=1 %h", io_axi_awvalid, got_aw, aw_prev);
                else n_pass++;
            end
            aw_stalled = io_axi_awvalid && !io_axi_awready; aw_prev = got_aw;
            if (io_axi_awvalid && io_axi_awready) begin
                aw_hs_cnt++;
                exp_aw = (exp_aw_q.size() > 0) ? exp_aw_q.pop_front() : 'x;
                n_checks++;
                if (got_aw !== exp_aw || io_axi_awid !== 1'b0 || io_axi_awsize !== 3'd6 || io_axi_awburst !== 2'b01)
                    $display("FAIL aw_beat: got len/addr %h id %b size %0d burst %0d want %h 0 6 1",
                             got_aw, io_axi_awid, io_axi_awsize, io_axi_awburst, exp_aw);
                else n_pass++;
            end
            got_w = {io_axi_wlast, io_axi_wdata};
            if (w_stalled) begin
                n_checks++;
                if (!io_axi_wvalid || got_w !== w_prev)
                    $display("FAIL w_stable: got v=%b last=%b d0=%h want v=1 last=%b d0=%h", io_axi_wvalid,
                             got_w[512], got_w[31:0], w_prev[512], w_prev[31:0]);
                else n_pass++;
            end
            w_stalled = io_axi_wvalid && !io_axi_wready; w_prev = got_w;
            if (io_axi_wvalid && io_axi_wready) begin
                w_hs_cnt++;
                if (io_axi_wlast) wl_hs_cnt++;
                exp_w = (exp_w_q.size() > 0) ? exp_w_q.pop_front() : 'x;
                n_checks++;
                if (got_w !== exp_w || io_axi_wstrb !== {64{1'b1}})
                    $display("FAIL w_beat %0d: got last=%b d=%h..%h strb=%h want last=%b d=%h..%h", w_hs_cnt - 1,
                             got_w[512], got_w[511:480], got_w[31:0], io_axi_wstrb, exp_w[512], exp_w[511:480], exp_w[31:0]);
                else n_pass++;
            end
        end
    end

    // Driver tasks
    task automatic push_job(input logic [63:0] addr, input logic [7:0] len, input logic [31:0] num,
                            input logic [7:0] stride);
        logic [31:0] b;
        for (int i = 0; i < int'(num); i++)
            exp_aw_q.push_back({len, addr + 64'(i) * 64'(stride) * 64'd64});
        for (int i = 0; i < int'(num) * (int'(len) + 1); i++) begin
            b = 32'(i);
            exp_w_q.push_back({1'((i % (int'(len) + 1)) == int'(len)), {16{b}}});
        end
    endtask

    task automatic clear_counts();
        @(negedge clk);
        aw_hs_cnt = 0; w_hs_cnt = 0; wl_hs_cnt = 0; b_sent = 0; any_valid = 0;
    endtask

    task automatic start_job(input logic [63:0] addr, input logic [7:0] len, input logic [31:0] num,
                             input logic [7:0] stride);
        push_job(addr, len, num, stride);
        @(posedge clk); #1;
        io_start_addr = addr; io_len_burst = len; io_num_burst = num; io_stride = stride;
        io_ap_start = 1'b1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin @(posedge clk); n++; end
        #1 io_ap_start = 1'b0;
        @(negedge clk);
    endtask

    // Scenario tasks
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({io_axi_awvalid, io_axi_wvalid, io_axi_wlast, io_ap_done, io_ap_ready, io_ap_idle, io_axi_bready} !== 7'b0000011
            || io_cnt_clk !== 32'd0)
            $display("FAIL reset_vals: got aw/w/last/done/ready/idle/bready=%b%b%b%b%b%b%b cnt=%0d want 0000011 cnt=0",
                     io_axi_awvalid, io_axi_wvalid, io_axi_wlast, io_ap_done, io_ap_ready, io_ap_idle, io_axi_bready, io_cnt_clk);
        else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int d0 = done_cnt;
        clear_counts();
        start_job(64'h1000, 8'd3, 32'd2, 8'd4);
        wait_done(d0 + 1, 500);
        n_checks++;
        if (done_cnt !== d0 + 1 || io_cnt_clk !== 32'(exp_cnt_clk) || exp_aw_q.size() != 0 || exp_w_q.size() != 0
            || aw_hs_cnt != 2 || w_hs_cnt != 8 || wl_hs_cnt != 2)
            $display("FAIL basic: done=%0d cnt=%0d aw=%0d w=%0d wl=%0d left=%0d/%0d want done=%0d cnt=%0d aw=2 w=8 wl=2 left=0/0",
                     done_cnt - d0, io_cnt_clk, aw_hs_cnt, w_hs_cnt, wl_hs_cnt, exp_aw_q.size(), exp_w_q.size(), 1, exp_cnt_clk);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt !== d0 + 1 || io_ap_idle !== 1'b1 || io_cnt_clk !== 32'(exp_cnt_clk))
            $display("FAIL basic_hold: done=%0d idle=%b cnt=%0d want 1 1 %0d", done_cnt - d0, io_ap_idle, io_cnt_clk, exp_cnt_clk);
        else n_pass++;
    endtask

    task automatic test_aw_stall();
        int d0 = done_cnt;
        clear_counts();
        aw_hold = 12;
        start_job(64'h2000, 8'd1, 32'd3, 8'd2);
        repeat (8) @(negedge clk);
        n_checks++;
        if (aw_hs_cnt != 0 || done_cnt != d0 || w_hs_cnt != 6)
            $display("FAIL aw_stall_mid: aw=%0d done=%0d w=%0d want 0 0 6", aw_hs_cnt, done_cnt - d0, w_hs_cnt);
        else n_pass++;
        wait_done(d0 + 1, 500);
        n_checks++;
        if (done_cnt !== d0 + 1 || io_cnt_clk !== 32'(exp_cnt_clk) || exp_aw_q.size() != 0 || exp_w_q.size() != 0
            || b_sent != 3)
            $display("FAIL aw_stall: done=%0d cnt=%0d left=%0d/%0d b=%0d want 1 %0d 0/0 3",
                     done_cnt - d0, io_cnt_clk, exp_aw_q.size(), exp_w_q.size(), b_sent, exp_cnt_clk);
        else n_pass++;
    endtask

    task automatic test_w_toggle();
        int d0 = done_cnt;
        clear_counts();
        w_toggle = 1;
        start_job(64'h4000, 8'd7, 32'd3, 8'd8);
        wait_done(d0 + 1, 800);
        w_toggle = 0;
        n_checks++;
        if (done_cnt !== d0 + 1 || w_hs_cnt != 24 || wl_hs_cnt != 3 || exp_w_q.size() != 0 || exp_aw_q.size() != 0)
            $display("FAIL w_toggle: done=%0d w=%0d wl=%0d left=%0d/%0d want 1 24 3 0/0",
                     done_cnt - d0, w_hs_cnt, wl_hs_cnt, exp_aw_q.size(), exp_w_q.size());
        else n_pass++;
    endtask

    task automatic test_num_zero();
        int d0 = done_cnt;
        clear_counts();
        start_job(64'h8000, 8'd3, 32'd0, 8'd1);
        wait_done(d0 + 1, 50);
        n_checks++;
        if (done_cnt !== d0 + 1 || io_cnt_clk !== 32'd1 || exp_cnt_clk != 1 || any_valid)
            $display("FAIL num_zero: done=%0d cnt=%0d span=%0d valid_seen=%b want 1 1 1 0",
                     done_cnt - d0, io_cnt_clk, exp_cnt_clk, any_valid);
        else n_pass++;
    endtask

    task automatic test_single_beat_random();
        int d0 = done_cnt;
        clear_counts();
        rand_ready = 1;
        start_job(64'h10000, 8'd0, 32'd6, 8'd1);
        wait_done(d0 + 1, 800);
        rand_ready = 0;
        n_checks++;
        if (done_cnt !== d0 + 1 || w_hs_cnt != 6 || wl_hs_cnt != 6 || io_cnt_clk !== 32'(exp_cnt_clk)
            || exp_w_q.size() != 0 || exp_aw_q.size() != 0)
            $display("FAIL single_beat: done=%0d w=%0d wl=%0d cnt=%0d left=%0d/%0d want 1 6 6 %0d 0/0",
                     done_cnt - d0, w_hs_cnt, wl_hs_cnt, io_cnt_clk, exp_aw_q.size(), exp_w_q.size(), exp_cnt_clk);
        else n_pass++;
    endtask

    task automatic test_addr_wrap();
        int d0 = done_cnt;
        clear_counts();
        start_job(64'hFFFF_FFFF_FFFF_FF00, 8'd0, 32'd3, 8'd255);
        wait_done(d0 + 1, 200);
        n_checks++;
        if (done_cnt !== d0 + 1 || aw_hs_cnt != 3 || exp_aw_q.size() != 0 || exp_w_q.size() != 0)
            $display("FAIL addr_wrap: done=%0d aw=%0d left=%0d/%0d want 1 3 0/0",
                     done_cnt - d0, aw_hs_cnt, exp_aw_q.size(), exp_w_q.size());
        else n_pass++;
    endtask

    task automatic test_b_delay();
        int d0 = done_cnt, n = 0;
        clear_counts();
        b_hold = 1;
        start_job(64'h20000, 8'd3, 32'd2, 8'd4);
        while (wl_hs_cnt < 2 && n < 200) begin @(posedge clk); n++; end
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (done_cnt != d0 || io_ap_idle !== 1'b0 || wl_hs_cnt != 2)
            $display("FAIL b_hold: done=%0d idle=%b wl=%0d want 0 0 2", done_cnt - d0, io_ap_idle, wl_hs_cnt);
        else n_pass++;
        b_hold = 0;
        wait_done(d0 + 1, 200);
        n_checks++;
        if (done_cnt !== d0 + 1 || io_cnt_clk !== 32'(exp_cnt_clk) || exp_cnt_clk < 28)
            $display("FAIL b_delay: done=%0d cnt=%0d span=%0d want 1 %0d >=28", done_cnt - d0, io_cnt_clk, exp_cnt_clk, exp_cnt_clk);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        clear_counts();
        push_job(64'h30000, 8'd1, 32'd2, 8'd2);
        start_job(64'h30000, 8'd1, 32'd2, 8'd2);
        wait_done(d0 + 2, 600);
        n_checks++;
        if (done_cnt !== d0 + 2 || w_hs_cnt != 8 || aw_hs_cnt != 4 || io_cnt_clk !== 32'(exp_cnt_clk)
            || exp_aw_q.size() != 0 || exp_w_q.size() != 0)
            $display("FAIL back_to_back: done=%0d aw=%0d w=%0d cnt=%0d left=%0d/%0d want 2 4 8 %0d 0/0",
                     done_cnt - d0, aw_hs_cnt, w_hs_cnt, io_cnt_clk, exp_aw_q.size(), exp_w_q.size(), exp_cnt_clk);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (io_ap_idle !== 1'b1 || done_cnt !== d0 + 2)
            $display("FAIL b2b_idle: idle=%b done=%0d want 1 2", io_ap_idle, done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int d0, n = 0;
        clear_counts();
        start_job(64'h40000, 8'd7, 32'd4, 8'd8);
        while (w_hs_cnt < 5 && n < 200) begin @(posedge clk); n++; end
        #1 reset = 1'b0; io_ap_start = 1'b0;
        #2;
        n_checks++;
        if ({io_axi_awvalid, io_axi_wvalid, io_axi_wlast, io_ap_done, io_ap_idle} !== 5'b00001 || io_cnt_clk !== 32'd0)
            $display("FAIL mid_reset: aw/w/last/done/idle=%b%b%b%b%b cnt=%0d want 00001 0",
                     io_axi_awvalid, io_axi_wvalid, io_axi_wlast, io_ap_done, io_ap_idle, io_cnt_clk);
        else n_pass++;
        running = 0; exp_aw_q.delete(); exp_w_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_counts();
        d0 = done_cnt;
        start_job(64'h50000, 8'd2, 32'd2, 8'd3);
        wait_done(d0 + 1, 300);
        n_checks++;
        if (done_cnt !== d0 + 1 || w_hs_cnt != 6 || io_cnt_clk !== 32'(exp_cnt_clk) || exp_aw_q.size() != 0
            || exp_w_q.size() != 0)
            $display("FAIL after_reset: done=%0d w=%0d cnt=%0d left=%0d/%0d want 1 6 %0d 0/0",
                     done_cnt - d0, w_hs_cnt, io_cnt_clk, exp_aw_q.size(), exp_w_q.size(), exp_cnt_clk);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_aw_stall();
        test_w_toggle();
        test_num_zero();
        test_single_beat_random();
        test_addr_wrap();
        test_b_delay();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
